snake_segment_store: RTL

Holds the snake body as an ordered list of segment top-left coordinates. Segment 0 is the head. The block sits directly upstream of the square draw/erase FSM and VGA adapter.
- On each game-tick `step`, it advances the head one cell in the requested direction with screen wrap-around, shifts the body, and optionally grows.
- It then scans the body for self-collision.
- The draw FSM reads segments through an indexed read port.

---
 rtl/snake_segment_store_if.sv | 41 ++++
 rtl/snake_segment_store.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/snake_segment_store_if.sv
// Control, read-port and status bundle between the game controller / draw FSM and snake_segment_store.
// Tail outputs exist only when SNAKE_TAIL_OUT_EN is defined.
interface snake_segment_store_if #(
    parameter int unsigned IW = 3,
    parameter int unsigned LW = 4
);
    logic          init;
    logic          step;
    logic [1:0]    dir;
    logic          grow;
    logic [IW-1:0] rd_idx;
    logic [7:0]    rd_x;
    logic [6:0]    rd_y;
    logic [LW-1:0] length;
    logic [7:0]    head_x;
    logic [6:0]    head_y;
    logic          busy;
    logic          scan_done;
    logic          collide;
`ifdef SNAKE_TAIL_OUT_EN
    logic [7:0]    tail_x;
    logic [6:0]    tail_y;
    logic          tail_valid;
`endif

    modport master (
`ifdef SNAKE_TAIL_OUT_EN
        input  tail_x, tail_y, tail_valid,
`endif
        output init, step, dir, grow, rd_idx,
        input  rd_x, rd_y, length, head_x, head_y, busy, scan_done, collide
    );

    modport slave (
`ifdef SNAKE_TAIL_OUT_EN
        output tail_x, tail_y, tail_valid,
`endif
        input  init, step, dir, grow, rd_idx,
        output rd_x, rd_y, length, head_x, head_y, busy, scan_done, collide
    );
endinterface

// File: rtl/snake_segment_store.sv
// Snake body store: head advance with wrap, body shift, growth, self-collision scan, indexed read port.
// Optional feature macro: SNAKE_TAIL_OUT_EN (vacated-tail outputs for incremental erase).
module snake_segment_store #(
    parameter int unsigned MAX_LEN  = 8,
    parameter int unsigned IW       = 3,
    parameter int unsigned LW       = 4,
    parameter int unsigned XDIM     = 10,
    parameter int unsigned YDIM     = 10,
    parameter int unsigned XSCREEN  = 160,
    parameter int unsigned YSCREEN  = 120,
    parameter int unsigned X_INIT   = 80,
    parameter int unsigned Y_INIT   = 30,
    parameter int unsigned INIT_LEN = 4
) (
    input  logic               CLOCK_50,
    input  logic               Resetn,
    snake_segment_store_if.slave bus
);
    localparam logic [1:0] DIR_UP = 2'b10;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
    } seg_t;

    typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

    seg_t          seg_q [MAX_LEN];
    logic [LW-1:0] len_q;
    logic [1:0]    last_dir_q;
    logic          collide_q;
    logic          busy_q, busy_d;
    logic          scan_done_q, scan_done_d;
    logic [IW-1:0] k_q, k_d;
    logic [7:0]    rd_x_q;
    logic [6:0]    rd_y_q;
    state_t        state_q, state_d;

    logic          step_ok_c;
    logic          grow_eff_c;
    logic          hit_c;
    logic [1:0]    dir_app_c;
    seg_t          new_head_c;
    logic [8:0]    x_inc_c;
    logic [7:0]    y_inc_c;

    assign step_ok_c  = bus.step && !busy_q && (len_q != '0) && !collide_q && !bus.init;
    assign grow_eff_c = bus.grow && (len_q < LW'(MAX_LEN));

    // A reversal request would fold the head onto the neck, so keep going the old way.
    assign dir_app_c = (bus.dir == ~last_dir_q) ? last_dir_q : bus.dir;

    assign x_inc_c = {1'b0, seg_q[0].x} + 9'(XDIM);
    assign y_inc_c = {1'b0, seg_q[0].y} + 8'(YDIM);

    always_comb begin
        new_head_c = seg_q[0];
        case (dir_app_c)
            2'b00: new_head_c.x = (x_inc_c >= 9'(XSCREEN)) ? 8'd0 : x_inc_c[7:0];
            2'b01: new_head_c.y = (y_inc_c >= 8'(YSCREEN)) ? 7'd0 : y_inc_c[6:0];
            2'b10: new_head_c.y = (seg_q[0].y == 7'd0) ? 7'(YSCREEN - YDIM)
                                                       : seg_q[0].y - 7'(YDIM);
            default: new_head_c.x = (seg_q[0].x == 8'd0) ? 8'(XSCREEN - XDIM)
                                                         : seg_q[0].x - 8'(XDIM);
        endcase
    end

    // Scan FSM state register
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Scan FSM next state: one head-vs-seg[k] compare per cycle
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        busy_d      = busy_q;
        scan_done_d = 1'b0;
        hit_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (step_ok_c) begin
                    state_d = SCAN;
                    k_d     = IW'(1);
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                hit_c = (LW'(k_q) < len_q) && (seg_q[k_q] == seg_q[0]);
                if (LW'(k_q) >= len_q - LW'(1)) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    scan_done_d = 1'b1;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.init) begin
            state_d     = IDLE;
            k_d         = '0;
            busy_d      = 1'b0;
            scan_done_d = 1'b0;
            hit_c       = 1'b0;
        end
    end

    // Body storage, length, direction memory, status and read port
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            for (int i = 0; i < int'(MAX_LEN); i++) seg_q[i] <= '0;
            len_q       <= '0;
            last_dir_q  <= DIR_UP;
            collide_q   <= 1'b0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
        end else begin
            busy_q      <= busy_d;
            scan_done_q <= scan_done_d;
            rd_x_q      <= (LW'(bus.rd_idx) < len_q) ? seg_q[bus.rd_idx].x : 8'd0;
            rd_y_q      <= (LW'(bus.rd_idx) < len_q) ? seg_q[bus.rd_idx].y : 7'd0;
            if (hit_c) collide_q <= 1'b1;
            if (bus.init) begin
                for (int i = 0; i < int'(MAX_LEN); i++) begin
                    if (i < int'(INIT_LEN)) begin
                        seg_q[i].x <= 8'(X_INIT);
                        seg_q[i].y <= 7'(Y_INIT + 32'(i) * YDIM);
                    end else begin
                        seg_q[i] <= '0;
                    end
                end
                len_q      <= LW'(INIT_LEN);
                last_dir_q <= DIR_UP;
                collide_q  <= 1'b0;
            end else if (step_ok_c) begin
                for (int i = int'(MAX_LEN) - 1; i > 0; i--) seg_q[i] <= seg_q[i-1];
                seg_q[0]   <= new_head_c;
                last_dir_q <= dir_app_c;
                if (grow_eff_c) len_q <= len_q + LW'(1);
            end
        end
    end

`ifdef SNAKE_TAIL_OUT_EN
    logic [7:0] tail_x_q;
    logic [6:0] tail_y_q;
    logic       tail_valid_q;

    // Cell vacated by a non-growing step, so the draw FSM erases just that square
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            tail_x_q     <= '0;
            tail_y_q     <= '0;
            tail_valid_q <= 1'b0;
        end else begin
            tail_valid_q <= 1'b0;
            if (step_ok_c && !grow_eff_c) begin
                tail_x_q     <= seg_q[IW'(len_q - LW'(1))].x;
                tail_y_q     <= seg_q[IW'(len_q - LW'(1))].y;
                tail_valid_q <= 1'b1;
            end
        end
    end

    assign bus.tail_x     = tail_x_q;
    assign bus.tail_y     = tail_y_q;
    assign bus.tail_valid = tail_valid_q;
`endif

    assign bus.rd_x      = rd_x_q;
    assign bus.rd_y      = rd_y_q;
    assign bus.length    = len_q;
    assign bus.head_x    = seg_q[0].x;
    assign bus.head_y    = seg_q[0].y;
    assign bus.busy      = busy_q;
    assign bus.scan_done = scan_done_q;
    assign bus.collide   = collide_q;
endmodule
